// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory-port arbiter: FSM states, owner codes, abort data pattern.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        ACK_I,
        ACK_D
    } arb_state_t;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    localparam logic [63:0] ALL_ONES = '1;

    function automatic arb_state_t busy_state(input logic owner);
        return (owner == REQ_D) ? BUSY_D : BUSY_I;
    endfunction

endpackage

// File: rtl/arb_wait_timer.sv
// BUSY watchdog: counts enabled cycles since clear; expired is high on the TIMEOUT-th enabled cycle.
// No backpressure; clr has priority over en.
module arb_wait_timer #(
    parameter int TIMEOUT = 31
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wait_cnt;

    assign expired = en && (wait_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (clr) begin
            wait_cnt <= '0;
        end else if (en && !expired) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one cache port between IF and MEM; D-first with starvation guard, flush and timeout abort.
// Latency: request seen in IDLE -> mem_req next cycle -> ack the cycle after mem_rdy (min 2); requesters stall until ack.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_flush,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    output logic              i_stall,
    input  logic              d_rd_req,
    input  logic              d_wr_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdy,
    output logic              err
);

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    arb_state_t  state;
    logic [3:0]  starve_cnt;
    logic        flush_pend;
    logic        i_ack_q;
    logic        busy;
    logic        expired;
    logic        d_pend;
    logic        i_ok;
    logic        grant_d;
    logic        grant_i;

    assign busy    = (state == BUSY_I) || (state == BUSY_D);
    assign d_pend  = d_rd_req | d_wr_req;
    assign i_ok    = i_rd_req & ~i_flush;
    // D normally wins; once I has been passed over STARVE_MAX times it goes first.
    assign grant_d = d_pend & ((starve_cnt < SMAX) | ~i_ok);
    assign grant_i = ~grant_d & i_ok;

    // A flush arriving in ACK_I still kills the completion pulse.
    assign i_ack   = i_ack_q & ~i_flush;
    assign i_stall = i_rd_req & ~i_ack;
    assign d_stall = d_pend & ~d_ack;

    arb_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (~busy),
        .en      (busy),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            i_ack_q    <= 1'b0;
            d_ack      <= 1'b0;
            err        <= 1'b0;
            starve_cnt <= '0;
            flush_pend <= 1'b0;
        end else begin
            i_ack_q <= 1'b0;
            d_ack   <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state     <= busy_state(REQ_D);
                        mem_req   <= 1'b1;
                        mem_we    <= d_wr_req;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        if (!i_rd_req) begin
                            starve_cnt <= '0;
                        end else if (starve_cnt < SMAX) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                    end else if (grant_i) begin
                        state      <= busy_state(REQ_I);
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= i_addr;
                        starve_cnt <= '0;
                        flush_pend <= 1'b0;
                    end
                end
                BUSY_I: begin
                    if (i_flush) begin
                        flush_pend <= 1'b1;
                    end
                    if (mem_rdy || expired) begin
                        mem_req <= 1'b0;
                        if (mem_rdy) begin
                            i_rdata <= mem_rdata;
                        end else begin
                            i_rdata <= ALL_ONES[DATA_W-1:0];
                            err     <= 1'b1;
                        end
                        // A redirected fetch still finishes on the bus but is never acknowledged.
                        if (flush_pend || i_flush) begin
                            state <= IDLE;
                        end else begin
                            state   <= ACK_I;
                            i_ack_q <= 1'b1;
                        end
                    end
                end
                BUSY_D: begin
                    if (mem_rdy || expired) begin
                        mem_req <= 1'b0;
                        if (mem_rdy) begin
                            if (!mem_we) begin
                                d_rdata <= mem_rdata;
                            end
                        end else begin
                            d_rdata <= ALL_ONES[DATA_W-1:0];
                            err     <= 1'b1;
                        end
                        state <= ACK_D;
                        d_ack <= 1'b1;
                    end
                end
                ACK_I, ACK_D: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed IF/MEM traffic against a responder modelling the cache.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_rd_req;
    logic [15:0] i_addr;
    logic        i_flush;
    logic [15:0] i_rdata;
    logic        i_ack;
    logic        i_stall;
    logic        d_rd_req;
    logic        d_wr_req;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_ack;
    logic        d_stall;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_rdy;
    logic        err;

    typedef struct packed {
        logic        is_d;
        logic        chk_data;
        logic [15:0] data;
    } rsp_t;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } bus_t;

    rsp_t rsp_q[$];
    bus_t bus_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   rsp_en;
    int   rsp_delay;
    int   n;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(16), .DATA_W(16), .STARVE_MAX(4), .TIMEOUT(31)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_rd_req  (i_rd_req),
        .i_addr    (i_addr),
        .i_flush   (i_flush),
        .i_rdata   (i_rdata),
        .i_ack     (i_ack),
        .i_stall   (i_stall),
        .d_rd_req  (d_rd_req),
        .d_wr_req  (d_wr_req),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .d_stall   (d_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_rdy   (mem_rdy),
        .err       (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rsp(input logic is_d, input logic [15:0] data);
        rsp_t e;
        if (rsp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ack: got ack on port %0d data 0x%0h, expected no ack", is_d, data);
        end else begin
            e = rsp_q.pop_front();
            chk("ack_port", {31'd0, is_d}, {31'd0, e.is_d});
            if (e.chk_data) chk("ack_data", {16'd0, data}, {16'd0, e.data});
        end
    endtask

    task automatic check_bus();
        bus_t e;
        if (bus_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_bus: got access addr 0x%0h we %0d, expected none", mem_addr, mem_we);
        end else begin
            e = bus_q.pop_front();
            chk("bus_we", {31'd0, mem_we}, {31'd0, e.we});
            chk("bus_addr", {16'd0, mem_addr}, {16'd0, e.addr});
            if (e.we) chk("bus_wdata", {16'd0, mem_wdata}, {16'd0, e.wdata});
        end
    endtask

    task automatic wait_ack(input logic is_d, input int max, output int cnt);
        for (cnt = 0; cnt <= max; cnt++) begin
            @(negedge clk);
            if (is_d ? d_ack : i_ack) return;
        end
        checks++;
        failures++;
        $display("FAIL ack_wait: got no ack on port %0d within %0d cycles, expected one", is_d, max);
    endtask

    task automatic wait_memreq(input int max);
        for (int c = 0; c <= max; c++) begin
            @(negedge clk);
            if (mem_req) return;
        end
        checks++;
        failures++;
        $display("FAIL memreq_wait: got mem_req low for %0d cycles, expected high", max);
    endtask

    // Output monitor: every ack is matched against the oldest expected response.
    initial begin
        forever begin
            @(negedge clk);
            if (i_ack) check_rsp(1'b0, i_rdata);
            if (d_ack) check_rsp(1'b1, d_rdata);
        end
    end

    // Cache model: answers rsp_delay cycles into mem_req with data = addr ^ 0xB133.
    initial begin
        int wn;
        wn        = 0;
        mem_rdy   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req && rsp_en) begin
                if (wn >= rsp_delay) begin
                    mem_rdy   = 1'b1;
                    mem_rdata = mem_addr ^ 16'hB133;
                    check_bus();
                    wn = 0;
                end else begin
                    mem_rdy = 1'b0;
                    wn++;
                end
            end else begin
                mem_rdy = 1'b0;
                wn      = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; i_rd_req = 1'b0; i_addr = '0; i_flush = 1'b0;
        d_rd_req = 1'b0; d_wr_req = 1'b0; d_addr = '0; d_wdata = '0;
        rsp_en = 1'b1; rsp_delay = 0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", {31'd0, mem_req}, 0);
        chk("rst_mem_we", {31'd0, mem_we}, 0);
        chk("rst_i_ack", {31'd0, i_ack}, 0);
        chk("rst_d_ack", {31'd0, d_ack}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_mem_addr", {16'd0, mem_addr}, 0);
        chk("rst_mem_wdata", {16'd0, mem_wdata}, 0);
        chk("rst_i_rdata", {16'd0, i_rdata}, 0);
        chk("rst_d_rdata", {16'd0, d_rdata}, 0);
        chk("rst_stalls", {30'd0, i_stall, d_stall}, 0);
        tick();
        rst = 1'b1;
        tick();

        // Single fetch
        bus_q.push_back('{we: 1'b0, addr: 16'h0010, wdata: 16'h0000});
        rsp_q.push_back('{is_d: 1'b0, chk_data: 1'b1, data: 16'hB123});
        i_addr = 16'h0010; i_rd_req = 1'b1;
        @(negedge clk);
        chk("t1_stall_req", {31'd0, i_stall}, 1);
        wait_ack(1'b0, 10, n);
        chk("t1_latency", n + 1, 2);
        chk("t1_stall_at_ack", {31'd0, i_stall}, 0);
        tick();
        i_rd_req = 1'b0;
        @(negedge clk);
        chk("t1_stall_after", {31'd0, i_stall}, 0);
        tick();

        // Simultaneous I and D: store goes first
        bus_q.push_back('{we: 1'b1, addr: 16'h00F0, wdata: 16'h5A5A});
        bus_q.push_back('{we: 1'b0, addr: 16'h0020, wdata: 16'h0000});
        rsp_q.push_back('{is_d: 1'b1, chk_data: 1'b0, data: 16'h0000});
        rsp_q.push_back('{is_d: 1'b0, chk_data: 1'b1, data: 16'hB113});
        d_addr = 16'h00F0; d_wdata = 16'h5A5A; d_wr_req = 1'b1;
        i_addr = 16'h0020; i_rd_req = 1'b1;
        wait_ack(1'b1, 10, n);
        chk("t2_d_latency", n, 2);
        chk("t2_d_stall_at_ack", {31'd0, d_stall}, 0);
        chk("t2_i_stall_waiting", {31'd0, i_stall}, 1);
        tick();
        d_wr_req = 1'b0;
        wait_ack(1'b0, 10, n);
        chk("t2_i_after_d", n, 2);
        tick();
        i_rd_req = 1'b0;
        tick();

        // Starvation guard: four stores then the fetch
        for (int k = 0; k < 4; k++) begin
            bus_q.push_back('{we: 1'b1, addr: 16'h0100, wdata: 16'h1234});
            rsp_q.push_back('{is_d: 1'b1, chk_data: 1'b0, data: 16'h0000});
        end
        bus_q.push_back('{we: 1'b0, addr: 16'h0030, wdata: 16'h0000});
        rsp_q.push_back('{is_d: 1'b0, chk_data: 1'b1, data: 16'hB103});
        d_addr = 16'h0100; d_wdata = 16'h1234; d_wr_req = 1'b1;
        i_addr = 16'h0030; i_rd_req = 1'b1;
        wait_ack(1'b0, 60, n);
        chk("t3_i_after_4d", n, 14);
        tick();
        d_wr_req = 1'b0; i_rd_req = 1'b0;
        chk("t3_queue_drained", rsp_q.size(), 0);
        tick();

        // Flush during BUSY_I: old fetch finishes on the bus, only the new one acks
        rsp_delay = 3;
        bus_q.push_back('{we: 1'b0, addr: 16'h0040, wdata: 16'h0000});
        bus_q.push_back('{we: 1'b0, addr: 16'h0050, wdata: 16'h0000});
        rsp_q.push_back('{is_d: 1'b0, chk_data: 1'b1, data: 16'hB163});
        i_addr = 16'h0040; i_rd_req = 1'b1;
        wait_memreq(10);
        tick();
        i_flush = 1'b1; i_addr = 16'h0050;
        @(negedge clk);
        chk("t4_stall_in_flush", {31'd0, i_stall}, 1);
        tick();
        i_flush = 1'b0;
        wait_ack(1'b0, 20, n);
        chk("t4_refetch_latency", n, 7);
        tick();
        i_rd_req = 1'b0; rsp_delay = 0;
        @(negedge clk);
        chk("t4_no_err", {31'd0, err}, 0);
        tick();

        // Timeout abort on a load
        rsp_en = 1'b0;
        rsp_q.push_back('{is_d: 1'b1, chk_data: 1'b1, data: 16'hFFFF});
        d_addr = 16'h0200; d_rd_req = 1'b1;
        wait_ack(1'b1, 40, n);
        chk("t5_timeout_cycle", n, 32);
        chk("t5_err_set", {31'd0, err}, 1);
        chk("t5_mem_req_dropped", {31'd0, mem_req}, 0);
        tick();
        d_rd_req = 1'b0; rsp_en = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        chk("t5_err_sticky", {31'd0, err}, 1);
        tick();

        // Reset in BUSY_D: mem_req drops at once, no ack, err cleared
        rsp_en = 1'b0;
        d_addr = 16'h0300; d_rd_req = 1'b1;
        wait_memreq(10);
        tick();
        rst = 1'b0;
        #1;
        chk("t6_req_drop", {31'd0, mem_req}, 0);
        chk("t6_no_ack", {31'd0, d_ack}, 0);
        d_rd_req = 1'b0;
        tick();
        tick();
        rst = 1'b1; rsp_en = 1'b1;
        @(negedge clk);
        chk("t6_err_cleared", {31'd0, err}, 0);
        repeat (3) tick();
        @(negedge clk);
        chk("t6_idle_no_req", {31'd0, mem_req}, 0);
        tick();
        bus_q.push_back('{we: 1'b0, addr: 16'h0060, wdata: 16'h0000});
        rsp_q.push_back('{is_d: 1'b0, chk_data: 1'b1, data: 16'hB153});
        i_addr = 16'h0060; i_rd_req = 1'b1;
        wait_ack(1'b0, 10, n);
        chk("t6_fetch_after_reset", n, 2);
        tick();
        i_rd_req = 1'b0;

        repeat (3) tick();
        chk("end_rsp_q_empty", rsp_q.size(), 0);
        chk("end_bus_q_empty", bus_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
